// File: rtl/cdr_pkg.sv
// rtl/cdr_pkg.sv - shared types, constants and helpers for the CDR loop filter
//
// Purpose: decision type, FSM state enum, step clamp limits and a
// saturating add used by the integrator.
package cdr_pkg;

  // Window decision: -1 (early), 0 (inside deadband), +1 (late)
  typedef logic signed [1:0] decision_t;

  localparam decision_t D_NEG  = 2'sb11;
  localparam decision_t D_ZERO = 2'sb00;
  localparam decision_t D_POS  = 2'sb01;

  typedef enum logic {
    ACQ   = 1'b0,
    TRACK = 1'b1
  } cdr_state_t;

  localparam int STEP_MIN = 1;
  localparam int STEP_MAX = 255;

  // Symmetric saturation to +/-lim; the caller narrows the result.
  function automatic int sat_add(input int a, input int b, input int lim);
    int s;
    s = a + b;
    if (s > lim) begin
      return lim;
    end
    if (s < -lim) begin
      return -lim;
    end
    return s;
  endfunction

endpackage

// File: rtl/cdr_vote_window.sv
// rtl/cdr_vote_window.sv - bang-bang vote decimation with deadband decision
//
// Purpose: maps early/late samples to votes, sums them over VOTE_LEN
// qualified samples and registers one decision per window.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   i_pd_valid          phase-detector sample present
//   i_pd_early/late     sample direction, qualified by i_pd_valid
//   i_freeze            ignore samples, hold window state
//   o_d                 registered window decision
//   o_d_valid           one-cycle pulse the cycle after the closing sample
module cdr_vote_window
  import cdr_pkg::*;
#(
  parameter int VOTE_LEN = 8,
  parameter int DEADBAND = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_pd_valid,
  input  logic      i_pd_early,
  input  logic      i_pd_late,
  input  logic      i_freeze,
  output decision_t o_d,
  output logic      o_d_valid
);

  localparam int CW = $clog2(VOTE_LEN);
  localparam int SW = CW + 2;
  localparam logic [CW-1:0]        LAST_IDX = CW'(VOTE_LEN - 1);
  localparam logic signed [SW-1:0] DB_HI    = SW'(DEADBAND);
  localparam logic signed [SW-1:0] DB_LO    = -DB_HI;

  logic                 w_take;
  logic                 w_close;
  logic signed [SW-1:0] w_vote;
  logic signed [SW-1:0] w_sum;
  decision_t            w_dec;

  logic [CW-1:0]        r_cnt;
  logic signed [SW-1:0] r_sum;
  decision_t            r_d;
  logic                 r_d_valid;

  always_comb begin
    w_take  = i_pd_valid & ~i_freeze;
    w_close = w_take && (r_cnt == LAST_IDX);

    // Both or neither flag: zero vote, but the sample still counts.
    w_vote = '0;
    if (i_pd_late && !i_pd_early) begin
      w_vote = SW'(1);
    end else if (i_pd_early && !i_pd_late) begin
      w_vote = '1;
    end

    // The closing sample's vote is part of its own window's decision.
    w_sum = r_sum + w_vote;

    w_dec = D_ZERO;
    if (w_sum > DB_HI) begin
      w_dec = D_POS;
    end else if (w_sum < DB_LO) begin
      w_dec = D_NEG;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_sum     <= '0;
      r_d       <= D_ZERO;
      r_d_valid <= 1'b0;
    end else begin
      r_d_valid <= w_close;
      if (w_close) begin
        r_d <= w_dec;
      end
      if (w_take) begin
        if (w_close) begin
          r_cnt <= '0;
          r_sum <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
          r_sum <= w_sum;
        end
      end
    end
  end

  assign o_d       = r_d;
  assign o_d_valid = r_d_valid;

endmodule

// File: rtl/cdr_loop_filter.sv
// rtl/cdr_loop_filter.sv - PI loop filter producing the phase step word
//
// Purpose: integrates window decisions, forms NOM_STEP + P + I, clamps the
// result to an 8-bit step, and switches proportional gain via an
// acquire/track FSM.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   pd_valid            phase-detector sample present
//   pd_early, pd_late   sample direction, qualified by pd_valid
//   freeze              ignore samples and hold all state
//   step                unsigned phase increment to phase_generator
//   step_valid          one-cycle pulse when step updates
//   locked              high while the FSM is in TRACK
module cdr_loop_filter
  import cdr_pkg::*;
#(
  parameter int VOTE_LEN     = 8,
  parameter int DEADBAND     = 1,
  parameter int NOM_STEP     = 16,
  parameter int KP_SHIFT_ACQ = 3,
  parameter int KP_SHIFT_TRK = 1,
  parameter int KI_SHIFT     = 4,
  parameter int INT_WIDTH    = 12,
  parameter int LOCK_CNT     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pd_valid,
  input  logic       pd_early,
  input  logic       pd_late,
  input  logic       freeze,
  output logic [7:0] step,
  output logic       step_valid,
  output logic       locked
);

  localparam int RW      = INT_WIDTH + 2;
  localparam int INT_MAX = (1 << (INT_WIDTH - 1)) - 1;
  localparam int LCW     = $clog2(LOCK_CNT + 1);

  localparam logic [LCW-1:0]       LOCK_TGT = LCW'(LOCK_CNT);
  localparam logic signed [RW-1:0] NOM_RAW  = RW'(NOM_STEP);
  localparam logic signed [RW-1:0] RAW_MIN  = RW'(STEP_MIN);
  localparam logic signed [RW-1:0] RAW_MAX  = RW'(STEP_MAX);
  localparam logic [7:0]           NOM_W    = 8'(NOM_STEP);

  decision_t                   w_d;
  logic                        w_d_valid;

  logic signed [INT_WIDTH-1:0] w_integ_sum;
  logic signed [RW-1:0]        w_kp_term;
  logic signed [RW-1:0]        w_ki_term;
  logic signed [RW-1:0]        w_raw;
  logic [7:0]                  w_step_clamped;

  cdr_state_t                  w_state_n;
  logic [LCW-1:0]              w_lock_n;
  logic [LCW-1:0]              w_unlock_n;
  decision_t                   w_prev_d_n;
  logic signed [INT_WIDTH-1:0] w_integ_n;
  logic [7:0]                  w_step_n;

  cdr_state_t                  r_state;
  logic [LCW-1:0]              r_lock_cnt;
  logic [LCW-1:0]              r_unlock_cnt;
  decision_t                   r_prev_d;
  logic signed [INT_WIDTH-1:0] r_integ;
  logic [7:0]                  r_step;
  logic                        r_step_valid;

  cdr_vote_window #(
    .VOTE_LEN (VOTE_LEN),
    .DEADBAND (DEADBAND)
  ) u_vote_window (
    .clk        (clk),
    .rst        (rst),
    .i_pd_valid (pd_valid),
    .i_pd_early (pd_early),
    .i_pd_late  (pd_late),
    .i_freeze   (freeze),
    .o_d        (w_d),
    .o_d_valid  (w_d_valid)
  );

  // Datapath: the proportional gain is that of the state in force while
  // the window was collected, i.e. the current state before any transition.
  always_comb begin
    w_integ_sum = INT_WIDTH'(sat_add(int'(r_integ), int'(w_d), INT_MAX));
    w_kp_term   = (r_state == TRACK) ? (RW'(w_d) <<< KP_SHIFT_TRK)
                                     : (RW'(w_d) <<< KP_SHIFT_ACQ);
    w_ki_term   = RW'(w_integ_sum) >>> KI_SHIFT;
    w_raw       = NOM_RAW + w_kp_term + w_ki_term;

    w_step_clamped = w_raw[7:0];
    if (w_raw < RAW_MIN) begin
      w_step_clamped = 8'(STEP_MIN);
    end else if (w_raw > RAW_MAX) begin
      w_step_clamped = 8'(STEP_MAX);
    end
  end

  // Next-state: everything holds unless a decision arrives. A decision in
  // flight completes even under freeze, since freeze only gates sampling.
  always_comb begin
    w_state_n  = r_state;
    w_lock_n   = r_lock_cnt;
    w_unlock_n = r_unlock_cnt;
    w_prev_d_n = r_prev_d;
    w_integ_n  = r_integ;
    w_step_n   = r_step;

    if (w_d_valid) begin
      w_integ_n  = w_integ_sum;
      w_step_n   = w_step_clamped;
      w_prev_d_n = w_d;

      case (r_state)
        ACQ: begin
          w_lock_n = (w_d == D_ZERO) ? (r_lock_cnt + LCW'(1)) : '0;
          if (w_lock_n == LOCK_TGT) begin
            w_state_n  = TRACK;
            w_lock_n   = '0;
            w_unlock_n = '0;
          end
        end
        TRACK: begin
          // A run of identical nonzero decisions means the loop has slipped.
          if ((w_d != D_ZERO) && (w_d == r_prev_d)) begin
            w_unlock_n = r_unlock_cnt + LCW'(1);
          end else begin
            w_unlock_n = (w_d != D_ZERO) ? LCW'(1) : '0;
          end
          if (w_unlock_n == LOCK_TGT) begin
            w_state_n  = ACQ;
            w_lock_n   = '0;
            w_unlock_n = '0;
          end
        end
        default: begin
          w_state_n = ACQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ACQ;
      r_lock_cnt   <= '0;
      r_unlock_cnt <= '0;
      r_prev_d     <= D_ZERO;
      r_integ      <= '0;
      r_step       <= NOM_W;
      r_step_valid <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_lock_cnt   <= w_lock_n;
      r_unlock_cnt <= w_unlock_n;
      r_prev_d     <= w_prev_d_n;
      r_integ      <= w_integ_n;
      r_step       <= w_step_n;
      r_step_valid <= w_d_valid;
    end
  end

  assign step       = r_step;
  assign step_valid = r_step_valid;
  assign locked     = (r_state == TRACK);

endmodule

// File: tb/tb_cdr_loop_filter.sv
// tb/tb_cdr_loop_filter.sv - scoreboard bench for cdr_loop_filter
module tb_cdr_loop_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pd_valid = 1'b0;
  logic       pd_early = 1'b0;
  logic       pd_late = 1'b0;
  logic       freeze = 1'b0;
  logic [7:0] step;
  logic       step_valid;
  logic       locked;

  cdr_loop_filter dut (
    .clk        (clk),
    .rst        (rst),
    .pd_valid   (pd_valid),
    .pd_early   (pd_early),
    .pd_late    (pd_late),
    .freeze     (freeze),
    .step       (step),
    .step_valid (step_valid),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int step;
    bit locked;
    int cyc;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Reference model: plain arithmetic on the rules of the loop.
  int m_cnt, m_sum, m_integ, m_quiet, m_streak, m_prev;
  bit m_trk;

  function automatic int floor_div(input int x, input int m);
    if (x >= 0) return x / m;
    return -((-x + m - 1) / m);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_sum = 0; m_integ = 0;
    m_quiet = 0; m_streak = 0; m_prev = 0; m_trk = 0;
    q.delete();
  endtask

  task automatic model_window(input int sum);
    int d, gain, raw;
    exp_t e;
    d = (sum > 1) ? 1 : (sum < -1) ? -1 : 0;
    m_integ = m_integ + d;
    if (m_integ > 2047) m_integ = 2047;
    if (m_integ < -2047) m_integ = -2047;
    gain = m_trk ? 2 : 8;
    raw = 16 + d * gain + floor_div(m_integ, 16);
    e.step = (raw < 1) ? 1 : (raw > 255) ? 255 : raw;
    if (!m_trk) begin
      m_quiet = (d == 0) ? m_quiet + 1 : 0;
      if (m_quiet == 4) begin m_trk = 1; m_quiet = 0; m_streak = 0; end
    end else begin
      m_streak = (d != 0 && d == m_prev) ? m_streak + 1 : (d != 0 ? 1 : 0);
      if (m_streak == 4) begin m_trk = 0; m_quiet = 0; m_streak = 0; end
    end
    m_prev = d;
    e.locked = m_trk;
    e.cyc = cyc + 2;
    q.push_back(e);
  endtask

  // One cycle of stimulus, driven just after the rising edge.
  task automatic drive(input bit v, input bit e, input bit l, input bit f);
    @(posedge clk);
    #1;
    pd_valid = v; pd_early = e; pd_late = l; freeze = f;
    if (rst && v && !f) begin
      m_sum += (l && !e) ? 1 : ((e && !l) ? -1 : 0);
      m_cnt++;
      if (m_cnt == 8) begin
        model_window(m_sum);
        m_cnt = 0;
        m_sum = 0;
      end
    end
  endtask

  task automatic windows(input int n, input bit e, input bit l);
    for (int w = 0; w < n; w++)
      for (int s = 0; s < 8; s++) drive(1, e, l, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  // Monitor: compares every output cycle against the scoreboard.
  int cur_step = 16;
  bit cur_locked = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk(step == 8'd16, "reset_step", step, 16);
      chk(!step_valid && !locked, "reset_flags", {step_valid, locked}, 0);
      cur_step = 16;
      cur_locked = 0;
    end else if (step_valid) begin
      chk(q.size() != 0, "unexpected_step_valid", q.size(), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk(int'(step) == e.step, "step", step, e.step);
        chk(locked == e.locked, "locked", locked, e.locked);
        chk(cyc == e.cyc, "pulse_cycle", cyc, e.cyc);
        cur_step = e.step;
        cur_locked = e.locked;
      end
    end else begin
      chk(int'(step) == cur_step, "step_hold", step, cur_step);
      chk(locked == cur_locked, "locked_hold", locked, cur_locked);
    end
  end

  initial begin
    model_reset();
    // Reset held with inputs toggling.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      pd_valid = 1'($urandom); pd_early = 1'($urandom);
      pd_late = 1'($urandom); freeze = 1'($urandom);
    end
    @(posedge clk);
    #1;
    pd_valid = 0; pd_early = 0; pd_late = 0; freeze = 0;
    rst = 1;
    idle(3);

    // ACQ step: one all-late window.
    windows(1, 0, 1);
    idle(4);

    // Acquire lock: alternating early/late windows.
    for (int w = 0; w < 4; w++)
      for (int s = 0; s < 8; s++) drive(1, s[0], !s[0], 0);
    idle(4);

    // Loss of lock then ACQ gain.
    windows(5, 0, 1);
    idle(4);

    // Saturation then recovery.
    windows(2080, 1, 0);
    windows(20, 0, 1);
    idle(4);

    // Freeze mid-window.
    for (int s = 0; s < 3; s++) drive(1, 0, 1, 0);
    for (int s = 0; s < 20; s++) drive(1, 0, 1, 1);
    for (int s = 0; s < 5; s++) drive(1, 0, 1, 0);
    idle(4);

    // Reset mid-window: step returns to nominal at once.
    for (int s = 0; s < 3; s++) drive(1, 0, 1, 0);
    @(posedge clk);
    #1;
    pd_valid = 0;
    rst = 0;
    model_reset();
    #1;
    chk(step == 8'd16, "async_reset_step", step, 16);
    @(posedge clk);
    #1;
    rst = 1;
    windows(1, 0, 1);
    idle(4);

    // Randomized traffic, including freeze around window boundaries.
    for (int i = 0; i < 1500; i++)
      drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
            $urandom_range(0, 15) == 0);
    idle(6);

    chk(q.size() == 0, "scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cdr_loop_filter.md
Name: cdr_loop_filter

Overview:
- Digital PI loop filter directly upstream of phase_generator.
- Takes bang-bang early/late votes from the CDR phase detector and decimates them over fixed windows.
- Produces the per-cycle phase increment (step word) that phase_generator accumulates into its 8-bit phase.
- Contains an acquire/track gain-switching FSM with a lock indicator.

Parameters:
- VOTE_LEN, 8: number of pd_valid samples per decision window (power of 2, min 2).
- DEADBAND, 1: |vote_sum| <= DEADBAND yields decision 0.
- NOM_STEP, 16: nominal step word; 8-bit unsigned.
- KP_SHIFT_ACQ, 3: proportional gain in ACQ, applied as d << KP_SHIFT_ACQ.
- KP_SHIFT_TRK, 1: proportional gain in TRACK.
- KI_SHIFT, 4: integral term is integ >>> KI_SHIFT (arithmetic shift).
- INT_WIDTH, 12: signed integrator width.
- LOCK_CNT, 4: consecutive qualifying windows needed to change state.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- pd_valid  in  1  one phase-detector sample is present this cycle.
- pd_early  in  1  sample was early; qualified by pd_valid.
- pd_late  in  1  sample was late; qualified by pd_valid.
- freeze  in  1  while 1, pd_valid is ignored and all state holds.
- step  out  8  phase increment to phase_generator (unsigned).
- step_valid  out  1  one-cycle pulse when step updates.
- locked  out  1  1 while the FSM is in TRACK.

Behaviour:
- Reset (rst=0, async):
  - step=NOM_STEP, step_valid=0, locked=0, state=ACQ.
  - Integrator, vote_sum, window counter, lock/unlock counters and prev_d all cleared to 0.
- Vote mapping on pd_valid & ~freeze:
  - late-only = +1; early-only = -1.
  - both or neither = 0, but the sample still counts toward the window.
- vote_sum is signed, $clog2(VOTE_LEN)+2 bits. Window counter wraps at VOTE_LEN.
- Window close: the VOTE_LEN-th valid sample at cycle n.
  - d registered at n+1: +1 if vote_sum > DEADBAND, -1 if vote_sum < -DEADBAND, else 0.
  - vote_sum is restarted with the vote of that closing sample excluded, i.e. it restarts at 0 for the next window.
  - The next window starts at cycle n+1.
- Update at n+2:
  - integ += d, saturated to ±(2^(INT_WIDTH-1)-1); no wrap.
  - raw = NOM_STEP + (d << KP) + (integ_new >>> KI_SHIFT), computed at INT_WIDTH+2 bits signed.
  - KP is the gain for the state in force during that window.
  - step = clamp(raw, 1, 255); step_valid=1 for exactly that cycle.
  - Each window produces a step_valid pulse even when d=0.
- FSM ACQ:
  - A d=0 window increments lock_cnt; a nonzero d clears it.
  - When lock_cnt reaches LOCK_CNT: go to TRACK, locked=1 at the same n+2 edge, clear the counters.
- FSM TRACK:
  - A nonzero d equal to prev_d increments unlock_cnt; any other d sets it to (d!=0 ? 1 : 0).
  - When unlock_cnt reaches LOCK_CNT: go to ACQ, locked=0, clear the counters.
  - prev_d updates on every window.
- Gain switching takes effect from the next window's update. The integrator is not reset on state change.
- freeze:
  - Holds the window counter, vote_sum, integrator, FSM and step.
  - A decision/update already in flight (n+1/n+2) still completes.
- A mid-operation reset discards any in-flight decision; step returns to NOM_STEP immediately (async).

Decomposition:
- cdr_pkg holds:
  - the decision typedef (2-bit signed: -1/0/+1);
  - the state enum {ACQ, TRACK};
  - the STEP_MIN=1 / STEP_MAX=255 clamp constants;
  - a saturating-add function.
- Sub-module cdr_vote_window contains the vote mapping, window counter, vote_sum, deadband decision, and a d/d_valid output register.
- cdr_loop_filter instantiates cdr_vote_window and holds the integrator, FSM and output register.

Test Plan:
- Reset: hold rst=0, toggle inputs -> step=16, step_valid=0, locked=0; release rst -> outputs unchanged until the first window closes.
- ACQ step: 8 consecutive late samples -> step_valid pulse 2 cycles after the 8th sample, integ=1, step=16+8+0=24.
- Acquire lock: 4 windows of alternating early/late (vote_sum=0) -> locked=1 at the 4th update, step=16+(integ>>>4).
- Loss of lock: in TRACK, 4 windows of all-late -> first update step = 16 + 2 + (integ>>>4); locked drops at the 4th update; the 5th all-late window uses gain 8.
- Saturation/clamp: a long run of early-only windows -> integ pins at -2047, raw=16-8-128=-120 -> step=1, no wrap; then late windows -> integ recovers monotonically by 1 per window.
- freeze and reset: assert freeze mid-window for 20 cycles with pd_valid=1 -> no step_valid, window resumes at the same count. Then assert rst mid-window -> step=16 immediately, the next window needs 8 fresh samples.
